// File: rtl/uart_cmd_ctrl.sv
// UART command controller: parses SYNC/CMD/DATA/CHK frames, drives the LED register
// and answers each frame with ACK/NAK, plus the LED value for read commands.
module uart_cmd_ctrl #(
  parameter int         BYTE_TIMEOUT = 43400,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic       clkM,
  input  logic       rstM,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic [7:0] leds,
  output logic       busy,
  output logic       frame_err
);

  localparam int            CW      = $clog2(BYTE_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BYTE_TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [7:0]    ACK     = 8'h06;
  localparam logic [7:0]    NAK     = 8'h15;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GET_CMD   = 3'd1,
    GET_DATA  = 3'd2,
    GET_CHK   = 3'd3,
    EXEC      = 3'd4,
    SEND_ACK  = 3'd5,
    SEND_DATA = 3'd6,
    WAIT_TX   = 3'd7
  } state_t;

  state_t        stateR, stateS;
  logic [7:0]    cmdR, cmdS, dataR, dataS, chkR, chkS;
  logic [CW-1:0] cntR, cntS;
  logic          pendR, pendS, seenBusyR, seenBusyS;
  logic [7:0]    txDataR, txDataS, ledsR, ledsS;
  logic          txStartR, txStartS, busyR, frameErrR, frameErrS;

  function automatic logic [7:0] frameChk(input logic [7:0] c, input logic [7:0] d);
    return c ^ d;
  endfunction

  // Next-state, datapath and registered-output decode.
  always_comb begin
    stateS    = stateR;
    cmdS      = cmdR;
    dataS     = dataR;
    chkS      = chkR;
    cntS      = cntR;
    pendS     = pendR;
    seenBusyS = seenBusyR;
    txDataS   = txDataR;
    ledsS     = ledsR;
    txStartS  = 1'b0;
    frameErrS = 1'b0;
    case (stateR)
      IDLE: begin
        cntS = '0;
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          stateS = GET_CMD;
        end else begin
          stateS = IDLE;
        end
      end
      GET_CMD, GET_DATA, GET_CHK: begin
        // A byte arriving on the terminal-count cycle still counts.
        if (rx_valid) begin
          cntS = '0;
          case (stateR)
            GET_CMD:  begin cmdS  = rx_data; stateS = GET_DATA; end
            GET_DATA: begin dataS = rx_data; stateS = GET_CHK;  end
            default:  begin chkS  = rx_data; stateS = EXEC;     end
          endcase
        end else if (cntR == CNT_MAX) begin
          frameErrS = 1'b1;
          cntS      = '0;
          stateS    = IDLE;
        end else begin
          cntS = cntR + CNT_ONE;
        end
      end
      EXEC: begin
        stateS    = SEND_ACK;
        txStartS  = ~tx_busy;
        pendS     = 1'b0;
        seenBusyS = 1'b0;
        if (chkR != frameChk(cmdR, dataR)) begin
          txDataS   = NAK;
          frameErrS = 1'b1;
        end else begin
          case (cmdR)
            8'h01: begin ledsS = dataR; txDataS = ACK; end
            8'h02: begin pendS = 1'b1;  txDataS = ACK; end
            default: begin txDataS = NAK; frameErrS = 1'b1; end
          endcase
        end
      end
      SEND_ACK, SEND_DATA: begin
        // tx_start is high this cycle once txStartR is set; then hand off to WAIT_TX.
        if (txStartR) begin
          stateS    = WAIT_TX;
          seenBusyS = tx_busy;
        end else begin
          txStartS = ~tx_busy;
        end
      end
      WAIT_TX: begin
        if (tx_busy) begin
          seenBusyS = 1'b1;
        end else if (seenBusyR && pendR) begin
          stateS   = SEND_DATA;
          pendS    = 1'b0;
          txDataS  = ledsR;
          txStartS = 1'b1;
        end else if (seenBusyR) begin
          stateS = IDLE;
        end else begin
          stateS = WAIT_TX;
        end
      end
      default: stateS = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clkM) begin
    if (rstM) begin
      stateR    <= IDLE;
      cmdR      <= 8'h00;
      dataR     <= 8'h00;
      chkR      <= 8'h00;
      cntR      <= '0;
      pendR     <= 1'b0;
      seenBusyR <= 1'b0;
      txDataR   <= 8'h00;
      ledsR     <= 8'h00;
      txStartR  <= 1'b0;
      busyR     <= 1'b0;
      frameErrR <= 1'b0;
    end else begin
      stateR    <= stateS;
      cmdR      <= cmdS;
      dataR     <= dataS;
      chkR      <= chkS;
      cntR      <= cntS;
      pendR     <= pendS;
      seenBusyR <= seenBusyS;
      txDataR   <= txDataS;
      ledsR     <= ledsS;
      txStartR  <= txStartS;
      busyR     <= (stateS != IDLE);
      frameErrR <= frameErrS;
    end
  end

  assign tx_data   = txDataR;
  assign tx_start  = txStartR;
  assign leds      = ledsR;
  assign busy      = busyR;
  assign frame_err = frameErrR;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl with a small UART transmitter busy model.
module tb_uart_cmd_ctrl;
  localparam int TO = 40;

  logic       clkM = 1'b0;
  logic       rstM = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_busy = 1'b0;
  logic [7:0] tx_data, leds;
  logic       tx_start, busy, frame_err;

  int checks = 0, errors = 0;
  int startCnt = 0, errCnt = 0, overlapCnt = 0, busyLeft = 0;
  int s0, e0, n;
  logic holdBusy = 1'b0;
  logic [7:0] txLog[$];

  uart_cmd_ctrl #(.BYTE_TIMEOUT(TO), .SYNC_BYTE(8'hA5)) dut (
    .clkM(clkM), .rstM(rstM), .rx_data(rx_data), .rx_valid(rx_valid), .tx_busy(tx_busy),
    .tx_data(tx_data), .tx_start(tx_start), .leds(leds), .busy(busy), .frame_err(frame_err)
  );

  always #5 clkM = ~clkM;

  // Transmitter model: busy for 4 cycles after each tx_start; also counts pulses.
  initial begin
    forever begin
      @(negedge clkM);
      if (tx_start) begin
        startCnt++;
        txLog.push_back(tx_data);
        if (tx_busy) overlapCnt++;
        busyLeft = 4;
      end else if (busyLeft > 0) begin
        busyLeft--;
      end
      if (frame_err) errCnt++;
      tx_busy = holdBusy || (busyLeft > 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkM);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic sendFrame(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
    sendByte(b0); sendByte(b1); sendByte(b2); sendByte(b3);
  endtask

  task automatic waitIdle(input string tag);
    int k = 0;
    while (busy && k < 300) begin
      tick();
      k++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    tick(); tick();
    check("rst_leds", {24'd0, leds}, 32'h00);
    check("rst_txdata", {24'd0, tx_data}, 32'h00);
    check("rst_txstart", {31'd0, tx_start}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    rstM = 1'b0;
    tick();

    // Write command with latency check on the ACK.
    sendFrame(8'hA5, 8'h01, 8'h3C, 8'h3D);
    check("exec_nostart", {31'd0, tx_start}, 32'd0);
    check("exec_busy", {31'd0, busy}, 32'd1);
    tick();
    check("ack_latency", {31'd0, tx_start}, 32'd1);
    check("ack_data", {24'd0, tx_data}, 32'h06);
    check("wr_leds", {24'd0, leds}, 32'h3C);
    waitIdle("wr_idle");
    check("wr_starts", startCnt, 32'd1);
    check("wr_log0", {24'd0, txLog[0]}, 32'h06);

    // Read command: ACK followed by the LED value.
    sendFrame(8'hA5, 8'h02, 8'h00, 8'h02);
    waitIdle("rd_idle");
    check("rd_starts", startCnt, 32'd3);
    check("rd_log1", {24'd0, txLog[1]}, 32'h06);
    check("rd_log2", {24'd0, txLog[2]}, 32'h3C);
    check("rd_leds", {24'd0, leds}, 32'h3C);
    check("rd_overlap", overlapCnt, 32'd0);

    // Bad checksum and unknown command.
    e0 = errCnt;
    sendFrame(8'hA5, 8'h01, 8'h3C, 8'h00);
    tick();
    check("badchk_ferr", {31'd0, frame_err}, 32'd1);
    check("badchk_start", {31'd0, tx_start}, 32'd1);
    check("badchk_nak", {24'd0, tx_data}, 32'h15);
    tick();
    check("badchk_pulse", {31'd0, frame_err}, 32'd0);
    waitIdle("badchk_idle");
    sendFrame(8'hA5, 8'h01, 8'h77, 8'h00);
    waitIdle("badchk2_idle");
    check("badchk2_leds", {24'd0, leds}, 32'h3C);
    sendFrame(8'hA5, 8'h07, 8'h00, 8'h07);
    tick();
    check("badcmd_ferr", {31'd0, frame_err}, 32'd1);
    check("badcmd_nak", {24'd0, tx_data}, 32'h15);
    waitIdle("badcmd_idle");
    check("nak_errcnt", errCnt, e0 + 3);
    check("nak_starts", startCnt, 32'd6);

    // Junk in IDLE, then timeout after an incomplete frame.
    e0 = errCnt; s0 = startCnt;
    sendByte(8'h00); sendByte(8'hFF);
    tick(); tick(); tick();
    check("junk_noerr", errCnt, e0);
    check("junk_idle", {31'd0, busy}, 32'd0);
    sendByte(8'hA5); sendByte(8'h01);
    repeat (TO) tick();
    check("to_before_busy", {31'd0, busy}, 32'd1);
    check("to_before_ferr", {31'd0, frame_err}, 32'd0);
    tick();
    check("to_ferr", {31'd0, frame_err}, 32'd1);
    check("to_idle", {31'd0, busy}, 32'd0);
    tick();
    check("to_pulse", {31'd0, frame_err}, 32'd0);
    check("to_errcnt", errCnt, e0 + 1);
    check("to_nostart", startCnt, s0);

    // Byte landing on the terminal-count cycle wins.
    e0 = errCnt;
    sendByte(8'hA5);
    repeat (TO) tick();
    sendByte(8'h02);
    check("tc_noerr", {31'd0, frame_err}, 32'd0);
    check("tc_busy", {31'd0, busy}, 32'd1);
    sendByte(8'h00); sendByte(8'h02);
    waitIdle("tc_idle");
    check("tc_errcnt", errCnt, e0);
    check("tc_starts", startCnt, s0 + 2);
    check("tc_data", {24'd0, txLog[txLog.size()-1]}, 32'h3C);

    // Transmitter held busy across EXEC; ignored bytes; reset during WAIT_TX.
    s0 = startCnt;
    holdBusy = 1'b1;
    tick(); tick();
    sendFrame(8'hA5, 8'h01, 8'h0F, 8'h0E);
    repeat (100) tick();
    sendFrame(8'hA5, 8'h02, 8'h00, 8'h02);
    repeat (896) tick();
    check("hold_nostart", startCnt, s0);
    check("hold_busy", {31'd0, busy}, 32'd1);
    check("hold_leds", {24'd0, leds}, 32'h0F);
    holdBusy = 1'b0;
    n = 0;
    while (!tx_start && n < 10) begin
      tick();
      n++;
    end
    check("hold_start", {31'd0, tx_start}, 32'd1);
    check("hold_ack", {24'd0, tx_data}, 32'h06);
    tick(); tick();
    check("waittx_busy", {31'd0, busy}, 32'd1);
    rstM = 1'b1;
    tick();
    rstM = 1'b0;
    check("mid_rst_leds", {24'd0, leds}, 32'h00);
    check("mid_rst_txdata", {24'd0, tx_data}, 32'h00);
    check("mid_rst_txstart", {31'd0, tx_start}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
    repeat (30) tick();
    check("post_rst_starts", startCnt, s0 + 1);
    check("post_rst_idle", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
